somador_serial_param: RTL and testbench

//   Parametrised multi-cycle adder/subtractor, successor to the 8-bit dataflow full adder.

---
 rtl/somador_serial_param.sv | 120 ++++++++++++
 tb/tb_somador_serial_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial_param.sv
// rtl/somador_serial_param.sv - multi-cycle chunked adder/subtractor with start/busy/done handshake
module somador_serial_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_s;
  logic             r_sub;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  int               w_base;
  logic [CHUNK-1:0] w_xa;
  logic [CHUNK-1:0] w_yb;
  logic [CHUNK:0]   w_slice;
  logic [CHUNK-1:0] w_sum;
  logic             w_carry;
  logic             w_c_msb;

  // A new operation may start whenever no operation is in flight (IDLE or DONE)
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == LAST);
  assign w_base   = int'(r_cnt) * CHUNK;

  // Single CHUNK-bit slice; subtraction is x + ~y + ~borrow
  always_comb begin
    w_xa    = r_x[w_base +: CHUNK];
    w_yb    = r_sub ? ~r_y[w_base +: CHUNK] : r_y[w_base +: CHUNK];
    w_slice = {1'b0, w_xa} + {1'b0, w_yb} + {{CHUNK{1'b0}}, r_c};
    w_sum   = w_slice[CHUNK-1:0];
    w_carry = w_slice[CHUNK];
    // carry into the top bit of this slice, recovered from its sum bit
    w_c_msb = w_xa[CHUNK-1] ^ w_yb[CHUNK-1] ^ w_sum[CHUNK-1];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Operand latch, chunk-by-chunk result write and flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_s    <= '0;
      r_sub  <= 1'b0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_x   <= x;
      r_y   <= y;
      r_sub <= sub;
      r_c   <= sub ? ~cin : cin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_s[w_base +: CHUNK] <= w_sum;
      r_c                  <= w_carry;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_carry;
        r_ovf  <= w_c_msb ^ w_carry;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_somador_serial_param.sv
// tb/tb_somador_serial_param.sv - randomized and directed bench for somador_serial_param
module tb_somador_serial_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start_sw, sub_d, cin_d;
  logic [31:0] x_d, y_d;

  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic        cout0, cout1, cout2, cout3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [15:0] s0;
  logic [7:0]  s1, s2;
  logic [31:0] s3;

  logic [31:0] s_a [4];
  logic        done_a [4];
  logic        cout_a [4];
  logic        ovf_a [4];

  int wv [4] = '{16, 8, 8, 32};
  int nc [4] = '{4, 1, 8, 4};

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] cs [4];
  logic        cc [4];
  logic        cv [4];

  always #5 clk = ~clk;

  somador_serial_param #(.WIDTH(16), .CHUNK(4)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub_d), .x(x_d[15:0]), .y(y_d[15:0]),
    .cin(cin_d), .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));
  somador_serial_param #(.WIDTH(8), .CHUNK(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_sw), .sub(sub_d), .x(x_d[7:0]), .y(y_d[7:0]),
    .cin(cin_d), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
  somador_serial_param #(.WIDTH(8), .CHUNK(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_sw), .sub(sub_d), .x(x_d[7:0]), .y(y_d[7:0]),
    .cin(cin_d), .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));
  somador_serial_param #(.WIDTH(32), .CHUNK(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_sw), .sub(sub_d), .x(x_d), .y(y_d),
    .cin(cin_d), .busy(busy3), .done(done3), .s(s3), .cout(cout3), .ovf(ovf3));

  assign s_a[0] = {16'b0, s0};
  assign s_a[1] = {24'b0, s1};
  assign s_a[2] = {24'b0, s2};
  assign s_a[3] = s3;
  assign done_a[0] = done0;
  assign done_a[1] = done1;
  assign done_a[2] = done2;
  assign done_a[3] = done3;
  assign cout_a[0] = cout0;
  assign cout_a[1] = cout1;
  assign cout_a[2] = cout2;
  assign cout_a[3] = cout3;
  assign ovf_a[0] = ovf0;
  assign ovf_a[1] = ovf1;
  assign ovf_a[2] = ovf2;
  assign ovf_a[3] = ovf3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then reduce to WIDTH bits and signed range
  function automatic void model(input int w, input longint ux, input longint uy,
                                input bit sb, input bit ci,
                                output longint rs, output bit rc, output bit rv);
    longint m    = 64'sd1 <<< w;
    longint half = m / 2;
    longint sx   = (ux >= half) ? ux - m : ux;
    longint sy   = (uy >= half) ? uy - m : uy;
    longint res  = sb ? (ux - uy - longint'(ci)) : (ux + uy + longint'(ci));
    longint sres = sb ? (sx - sy - longint'(ci)) : (sx + sy + longint'(ci));
    rs = res & (m - 1);
    rc = sb ? (ux >= uy + longint'(ci)) : (res >= m);
    rv = (sres < -half) || (sres >= half);
  endfunction

  // One operation on all four instances; start0 optionally pulsed again mid-RUN
  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                        input bit sbv, input bit civ, input bit noisy);
    int     ndone [4];
    int     lat [4];
    longint es;
    bit     ec, ev;
    longint m;
    @(negedge clk);
    x_d = xv; y_d = yv; sub_d = sbv; cin_d = civ;
    start0 = 1'b1; start_sw = 1'b1;
    for (int k = 0; k < 4; k++) begin ndone[k] = 0; lat[k] = -1; end
    @(posedge clk);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (done_a[k]) begin
          ndone[k]++;
          lat[k] = cyc;
          cs[k]  = s_a[k];
          cc[k]  = cout_a[k];
          cv[k]  = ovf_a[k];
        end
      end
      start_sw = 1'b0;
      start0   = noisy && (cyc == 1 || cyc == 2);
      if (cyc == 0) begin
        x_d = $urandom; y_d = $urandom; sub_d = 1'($urandom); cin_d = 1'($urandom);
      end
    end
    for (int k = 0; k < 4; k++) begin
      m = (64'sd1 <<< wv[k]) - 1;
      model(wv[k], longint'(xv) & m, longint'(yv) & m, sbv, civ, es, ec, ev);
      check($sformatf("d%0d_ndone", k), 64'(ndone[k]), 64'd1);
      check($sformatf("d%0d_lat", k), 64'(lat[k]), 64'(nc[k]));
      check($sformatf("d%0d_s", k), 64'(cs[k]), 64'(es));
      check($sformatf("d%0d_cout", k), 64'(cc[k]), 64'(ec));
      check($sformatf("d%0d_ovf", k), 64'(cv[k]), 64'(ev));
    end
  endtask

  initial begin
    int     nd;
    int     dl [$];
    longint es;
    bit     ec, ev;

    rst_n = 1'b0; start0 = 1'b0; start_sw = 1'b0; sub_d = 1'b0; cin_d = 1'b0;
    x_d = '0; y_d = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_s", 64'(s0), 64'd0);
    check("rst_cout", 64'(cout0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    rst_n = 1'b1;

    // directed arithmetic cases
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
    check("t2_s", 64'(cs[0]), 64'h0001);
    check("t2_cout", 64'(cc[0]), 64'd1);
    check("t2_ovf", 64'(cv[0]), 64'd0);
    run_op(32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    check("t3_s", 64'(cs[0]), 64'h8000);
    check("t3_cout", 64'(cc[0]), 64'd0);
    check("t3_ovf", 64'(cv[0]), 64'd1);
    run_op(32'h00000008, 32'h00000001, 1'b1, 1'b1, 1'b0);
    check("t4a_s", 64'(cs[0]), 64'h0006);
    check("t4a_cout", 64'(cc[0]), 64'd1);
    check("t4a_ovf", 64'(cv[0]), 64'd0);
    run_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0);
    check("t4b_s", 64'(cs[0]), 64'hFFFF);
    check("t4b_cout", 64'(cc[0]), 64'd0);
    check("t4b_ovf", 64'(cv[0]), 64'd0);

    // reset two cycles into RUN aborts without a done pulse
    @(negedge clk);
    x_d = 32'h1234; y_d = 32'h4321; sub_d = 1'b0; cin_d = 1'b1; start0 = 1'b1; start_sw = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start_sw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_busy", 64'(busy0), 64'd0);
    check("t1_s", 64'(s0), 64'd0);
    check("t1_done", 64'(done0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    check("t1_nodone", 64'(nd), 64'd0);
    run_op(32'h00001234, 32'h00004321, 1'b0, 1'b1, 1'b0);

    // start held high through DONE: three ops back to back
    @(negedge clk);
    x_d = 32'h0000A5A5; y_d = 32'h00005A5B; sub_d = 1'b1; cin_d = 1'b0; start0 = 1'b1;
    model(16, 64'h0000A5A5, 64'h00005A5B, 1'b1, 1'b0, es, ec, ev);
    @(posedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done0) begin
        dl.push_back(cyc);
        check("t5_s", 64'(s0), 64'(es));
        check("t5_cout", 64'(cout0), 64'(ec));
        check("t5_ovf", 64'(ovf0), 64'(ev));
      end
      start0 = (cyc < 13);
    end
    check("t5_ndone", 64'(dl.size()), 64'd3);
    for (int i = 0; i < dl.size(); i++)
      check($sformatf("t5_lat%0d", i), 64'(dl[i]), 64'(4 + 5 * i));

    // mid-RUN start pulses are ignored
    run_op(32'h00003C3C, 32'h00000F0F, 1'b0, 1'b0, 1'b1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1);

    // random sweep across all four parameter sets
    for (int i = 0; i < 40; i++)
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
